prog_buffer: RTL and testbench

Parametrised successor to the CPU program-load FIFO. It is a true circular FIFO with independent write and read pointers, an occupancy count, first-word-fall-through output, sticky error flags, a synchronous flush and an almost-full threshold. It keeps a PC-indexed random-access read port so the 8-bit CPU can fetch instructions from the loaded image. It sits between the program loader (UART/host writer) and the CPU fetch stage.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/prog_buffer_if.sv | 39 +++
 rtl/prog_buffer_mem.sv | 41 ++++
 rtl/prog_buffer.sv | 109 ++++++++++
 tb/tb_prog_buffer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg
// Shared CPU-side constants: default word width, default program depth and
// the occupancy threshold helper used by the program-load buffer.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int CPU_DATA_W     = 8;
  localparam int CPU_PROG_DEPTH = 32;

  // Default almost-full threshold: leave one eighth of the storage as headroom
  // so the loader has time to back off (32 -> 28).
  function automatic int cpu_af_level(input int depth);
    return depth - (depth / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_buffer_if.sv
`default_nettype none
// ============================================================================
// prog_buffer_if
// Loader/CPU-side signal bundle of the program buffer. The master modport is
// the loader + fetch side, the slave modport is the buffer itself.
// Revision: 1.0
// ============================================================================
interface prog_buffer_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 5
);

  logic              Clear;
  logic              WR;
  logic [DATA_W-1:0] data_in;
  logic              RD;
  logic              Lock;
  logic [AW-1:0]     PC;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_pc;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output Clear, WR, data_in, RD, Lock, PC,
    input  data_out, data_pc, count, full, empty, almost_full, overflow, underflow
  );

  modport slave (
    input  Clear, WR, data_in, RD, Lock, PC,
    output data_out, data_pc, count, full, empty, almost_full, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/prog_buffer_mem.sv
`default_nettype none
// ============================================================================
// prog_buffer_mem
// DEPTH x DATA_W register array with one write port and two combinational
// read ports (FIFO head and CPU PC). Cleared to zero by the async reset.
// Revision: 1.0
// ============================================================================
module prog_buffer_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  wire logic              CPU_Clk,
  input  wire logic              Reset_n,
  input  wire logic              we_i,
  input  wire logic [AW-1:0]     waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [AW-1:0]     head_addr_i,
  output      logic [DATA_W-1:0] head_data_o,
  input  wire logic [AW-1:0]     pc_addr_i,
  output      logic [DATA_W-1:0] pc_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: every word cleared on reset so no stale image survives it.
  always_ff @(posedge CPU_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign head_data_o = mem_q[head_addr_i];
  assign pc_data_o   = mem_q[pc_addr_i];

endmodule
`default_nettype wire

// File: rtl/prog_buffer.sv
`default_nettype none
// ============================================================================
// prog_buffer
// Circular first-word-fall-through program-load FIFO with occupancy count,
// sticky overflow/underflow flags, synchronous flush, almost-full threshold
// and a PC-indexed random-access read port for instruction fetch.
// Revision: 1.0
// ============================================================================
module prog_buffer
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int DEPTH    = CPU_PROG_DEPTH,
  parameter int AF_LEVEL = cpu_af_level(CPU_PROG_DEPTH),
  localparam int AW      = $clog2(DEPTH)
) (
  input  wire logic     CPU_Clk,
  input  wire logic     Reset_n,
  prog_buffer_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, empty, wr_ok, rd_ok, mem_we;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // Acceptance is decided on the pre-edge occupancy only: a full buffer never
  // takes a write even if a pop happens in the same cycle, and vice versa.
  assign wr_ok  = bus.WR & ~full;
  assign rd_ok  = bus.RD & ~empty & ~bus.Lock;
  // Flush wins over a simultaneous push, so storage is left alone then.
  assign mem_we = wr_ok & ~bus.Clear;

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.Clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q  | (bus.WR & full);
      underflow_d = underflow_q | (bus.RD & empty & ~bus.Lock);
    end
  end

  // Control state register.
  always_ff @(posedge CPU_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  prog_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .CPU_Clk     (CPU_Clk),
    .Reset_n     (Reset_n),
    .we_i        (mem_we),
    .waddr_i     (wr_ptr_q),
    .wdata_i     (bus.data_in),
    .head_addr_i (rd_ptr_q),
    .head_data_o (bus.data_out),
    .pc_addr_i   (bus.PC),
    .pc_data_o   (bus.data_pc)
  );

  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count_q >= AF_CNT);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_buffer.sv
`default_nettype none
// ============================================================================
// tb_prog_buffer
// Self-checking bench for prog_buffer: directed scenarios plus randomized
// traffic, checked against a queue/array reference model in a monitor.
// Revision: 1.0
// ============================================================================
module tb_prog_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int AF    = 28;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prog_buffer_if #(.DATA_W(DW), .AW(AW)) bus ();

  prog_buffer #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .CPU_Clk (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: absolute storage image plus a queue of expected words.
  logic [DW-1:0] img [DEPTH];
  logic [DW-1:0] sb [$];
  int hd = 0;
  int wp = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model for the
  // upcoming edge using the inputs currently presented.
  always @(negedge clk) begin
    bit w_ok, r_ok;
    if (!rst_n) begin
      sb.delete();
      hd = 0; wp = 0; m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < DEPTH; i++) img[i] = '0;
    end
    chk("count",       32'(bus.count), 32'(sb.size()));
    chk("empty",       32'(bus.empty), 32'(sb.size() == 0));
    chk("full",        32'(bus.full), 32'(sb.size() == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(sb.size() >= AF));
    chk("overflow",    32'(bus.overflow), 32'(m_ovf));
    chk("underflow",   32'(bus.underflow), 32'(m_unf));
    if (sb.size() > 0) chk("head", 32'(bus.data_out), 32'(sb[0]));
    else               chk("head_idle", 32'(bus.data_out), 32'(img[hd]));
    chk("data_pc", 32'(bus.data_pc), 32'(img[bus.PC]));
    if (rst_n) begin
      if (bus.Clear) begin
        sb.delete();
        hd = 0; wp = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        w_ok = bus.WR && (sb.size() < DEPTH);
        r_ok = bus.RD && (sb.size() > 0) && !bus.Lock;
        if (bus.WR && sb.size() == DEPTH) m_ovf = 1'b1;
        if (bus.RD && sb.size() == 0 && !bus.Lock) m_unf = 1'b1;
        if (r_ok) begin
          void'(sb.pop_front());
          hd = (hd + 1) % DEPTH;
        end
        if (w_ok) begin
          img[wp] = bus.data_in;
          sb.push_back(bus.data_in);
          wp = (wp + 1) % DEPTH;
        end
      end
    end
  end

  task automatic drive(input bit wr, input bit rd, input logic [DW-1:0] d,
                       input bit lk, input bit clr);
    @(posedge clk);
    #1;
    bus.WR = wr; bus.RD = rd; bus.data_in = d; bus.Lock = lk; bus.Clear = clr;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [DW-1:0] pc_ref;

  initial begin
    bus.Clear = 0; bus.WR = 0; bus.RD = 0; bus.Lock = 0;
    bus.data_in = '0; bus.PC = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_dout",  32'(bus.data_out), 32'd0);
    chk("rst_dpc",   32'(bus.data_pc), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: three pushes, then one pop.
    drive(1, 0, 8'h11, 0, 0);
    drive(1, 0, 8'h22, 0, 0);
    drive(1, 0, 8'h33, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_dout",  32'(bus.data_out), 32'h11);
    chk("t1_empty", 32'(bus.empty), 32'd0);
    drive(0, 1, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t1_pop_dout",  32'(bus.data_out), 32'h22);
    chk("t1_pop_count", 32'(bus.count), 32'd2);

    // 2: fill 0x00..0x1F, check threshold and overflow.
    drive(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 27; i++) drive(1, 0, 8'(i), 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t2_af27", 32'(bus.almost_full), 32'd0);
    drive(1, 0, 8'd27, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t2_af28", 32'(bus.almost_full), 32'd1);
    for (int i = 28; i < 32; i++) drive(1, 0, 8'(i), 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t2_full", 32'(bus.full), 32'd1);
    drive(1, 0, 8'hAA, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    bus.PC = '0;
    #1;
    chk("t2_ovf",   32'(bus.overflow), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd32);
    chk("t2_pc0",   32'(bus.data_pc), 32'h00);

    // 3: WR+RD while full, drain, refill across the pointer wrap.
    drive(1, 1, 8'hBB, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t3_count", 32'(bus.count), 32'd31);
    chk("t3_dout",  32'(bus.data_out), 32'h01);
    for (int i = 0; i < 31; i++) drive(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 45; i++) drive(1, 1'(i % 2), 8'($urandom), 0, 0);
    for (int i = 0; i < 25; i++) drive(0, 1, 8'h00, 0, 0);

    // 4: WR+RD while empty.
    drive(0, 0, 8'h00, 0, 1);
    drive(1, 1, 8'h5A, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t4_count", 32'(bus.count), 32'd1);
    chk("t4_unf",   32'(bus.underflow), 32'd1);
    chk("t4_dout",  32'(bus.data_out), 32'h5A);

    // 5: Lock freezes pops, PC reads, writes still honoured.
    drive(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 8'hA0 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h00, 1, 0);
    drive(0, 0, 8'h00, 1, 0);
    settle();
    chk("t5_count", 32'(bus.count), 32'd4);
    chk("t5_unf",   32'(bus.underflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.PC = AW'(i);
      #1;
      chk("t5_pc", 32'(bus.data_pc), 32'hA0 + 32'(i));
    end
    drive(1, 0, 8'h77, 1, 0);
    drive(0, 0, 8'h00, 1, 0);
    settle();
    chk("t5_wr_locked", 32'(bus.count), 32'd5);
    drive(0, 0, 8'h00, 0, 0);

    // 6: Clear with overflow set and count 10, then async reset mid-push.
    drive(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 33; i++) drive(1, 0, 8'h40 + 8'(i), 0, 0);
    for (int i = 0; i < 22; i++) drive(0, 1, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    chk("t6_pre_count", 32'(bus.count), 32'd10);
    chk("t6_pre_ovf",   32'(bus.overflow), 32'd1);
    drive(0, 0, 8'h00, 0, 1);
    drive(0, 0, 8'h00, 0, 0);
    settle();
    bus.PC = 5'd2;
    #1;
    chk("t6_clr_count", 32'(bus.count), 32'd0);
    chk("t6_clr_empty", 32'(bus.empty), 32'd1);
    chk("t6_clr_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    chk("t6_clr_pc2",   32'(bus.data_pc), 32'h42);
    drive(1, 0, 8'h99, 0, 0);
    drive(1, 0, 8'h9A, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_full",  32'(bus.full), 32'd0);
    chk("t6_rst_af",    32'(bus.almost_full), 32'd0);
    chk("t6_rst_dout",  32'(bus.data_out), 32'd0);
    chk("t6_rst_pc2",   32'(bus.data_pc), 32'd0);
    drive(0, 0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic with phases biased toward fill, drain or balance.
    pc_ref = '0;
    for (int c = 0; c < 3000; c++) begin
      int mode;
      int pw, pr;
      mode = (c / 200) % 3;
      pw = (mode == 0) ? 80 : (mode == 1) ? 25 : 50;
      pr = (mode == 0) ? 25 : (mode == 1) ? 80 : 50;
      @(posedge clk);
      #1;
      rst_n       = ($urandom_range(0, 699) != 0);
      bus.WR      = ($urandom_range(0, 99) < pw);
      bus.RD      = ($urandom_range(0, 99) < pr);
      bus.data_in = 8'($urandom);
      bus.Clear   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 39) == 0) bus.Lock = ~bus.Lock;
      pc_ref      = 8'($urandom);
      bus.PC      = pc_ref[AW-1:0];
    end
    drive(0, 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
